// File: rtl/mcpu_avl_arb.sv
// Two-port round-robin arbiter in front of the memory controller's Avalon-MM burst port.
// Write bursts hold the grant until their last beat; read data is routed back through a tag FIFO.
module mcpu_avl_arb #(
  parameter int AW       = 25,
  parameter int DW       = 128,
  parameter int BEW      = 16,
  parameter int SW       = 5,
  parameter int RD_DEPTH = 4
) (
  input  logic           clkrst_avl_clk,
  input  logic           clkrst_avl_rst,
  input  logic [AW-1:0]  m0_addr,
  input  logic [BEW-1:0] m0_be,
  input  logic [DW-1:0]  m0_wdata,
  input  logic [SW-1:0]  m0_size,
  input  logic           m0_burstbegin,
  input  logic           m0_read_req,
  input  logic           m0_write_req,
  output logic           m0_ready,
  output logic [DW-1:0]  m0_rdata,
  output logic           m0_rdata_valid,
  input  logic [AW-1:0]  m1_addr,
  input  logic [BEW-1:0] m1_be,
  input  logic [DW-1:0]  m1_wdata,
  input  logic [SW-1:0]  m1_size,
  input  logic           m1_burstbegin,
  input  logic           m1_read_req,
  input  logic           m1_write_req,
  output logic           m1_ready,
  output logic [DW-1:0]  m1_rdata,
  output logic           m1_rdata_valid,
  output logic [AW-1:0]  ltc2mc_avl_addr_0,
  output logic [BEW-1:0] ltc2mc_avl_be_0,
  output logic [DW-1:0]  ltc2mc_avl_wdata_0,
  output logic [SW-1:0]  ltc2mc_avl_size_0,
  output logic           ltc2mc_avl_burstbegin_0,
  output logic           ltc2mc_avl_read_req_0,
  output logic           ltc2mc_avl_write_req_0,
  input  logic           ltc2mc_avl_ready_0,
  input  logic [DW-1:0]  ltc2mc_avl_rdata_0,
  input  logic           ltc2mc_avl_rdata_valid_0,
  output logic           err_unexp_rdata,
  output logic           dbg_state_o
);

  localparam int PW = $clog2(RD_DEPTH);
  localparam logic [0:0]    ST_IDLE   = 1'b0;
  localparam logic [0:0]    ST_WBURST = 1'b1;
  localparam logic [SW-1:0] SZ_ONE    = {{(SW-1){1'b0}}, 1'b1};
  localparam logic [PW:0]   PTR_ONE   = {{PW{1'b0}}, 1'b1};

  logic [0:0]    state_q, state_d;
  logic          last_grant_q, last_grant_d;
  logic          owner_q, owner_d;
  logic [SW-1:0] beats_left_q, beats_left_d;
  logic [SW-1:0] ret_cnt_q, ret_cnt_d;
  logic [PW:0]   wr_ptr_q, rd_ptr_q;
  logic          err_q;
  logic          tag_id_q   [RD_DEPTH];
  logic [SW-1:0] tag_size_q [RD_DEPTH];

  function automatic logic [SW-1:0] eff_size(input logic [SW-1:0] s);
    return (s == '0) ? SZ_ONE : s;
  endfunction

  logic fifo_empty, fifo_full, in_burst;
  logic cand0, cand1, win_id, sel_id, active, accept, push, pop, rvalid;
  logic head_id;
  logic [SW-1:0] head_size, ret_rem;
  logic sel_read_req, sel_write_req, sel_burstbegin;
  logic [SW-1:0] sel_size;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]) && (wr_ptr_q[PW] != rd_ptr_q[PW]);
  assign in_burst   = (state_q == ST_WBURST);

  // A pending read is only a candidate while the tag FIFO can take its tag.
  assign cand0  = m0_read_req ? ~fifo_full : (m0_write_req & m0_burstbegin);
  assign cand1  = m1_read_req ? ~fifo_full : (m1_write_req & m1_burstbegin);
  assign win_id = (cand0 & cand1) ? ~last_grant_q : cand1;
  assign sel_id = in_burst ? owner_q : win_id;
  assign active = ~clkrst_avl_rst & (in_burst | cand0 | cand1);
  assign accept = active & ltc2mc_avl_ready_0;

  assign sel_read_req   = sel_id ? m1_read_req   : m0_read_req;
  assign sel_write_req  = sel_id ? m1_write_req  : m0_write_req;
  assign sel_burstbegin = sel_id ? m1_burstbegin : m0_burstbegin;
  assign sel_size       = sel_id ? m1_size       : m0_size;

  assign ltc2mc_avl_addr_0       = sel_id ? m1_addr  : m0_addr;
  assign ltc2mc_avl_be_0         = sel_id ? m1_be    : m0_be;
  assign ltc2mc_avl_wdata_0      = sel_id ? m1_wdata : m0_wdata;
  assign ltc2mc_avl_size_0       = sel_size;
  assign ltc2mc_avl_read_req_0   = active & ~in_burst & sel_read_req;
  assign ltc2mc_avl_write_req_0  = active & sel_write_req & (in_burst | ~sel_read_req);
  assign ltc2mc_avl_burstbegin_0 = active & ~in_burst & sel_burstbegin;

  assign m0_ready = accept & ~sel_id;
  assign m1_ready = accept &  sel_id;

  // Return path: every controller beat belongs to the oldest outstanding read burst.
  assign rvalid    = ltc2mc_avl_rdata_valid_0 & ~clkrst_avl_rst;
  assign head_id   = tag_id_q[rd_ptr_q[PW-1:0]];
  assign head_size = tag_size_q[rd_ptr_q[PW-1:0]];
  assign ret_rem   = (ret_cnt_q == '0) ? eff_size(head_size) : ret_cnt_q;
  assign pop       = rvalid & ~fifo_empty & (ret_rem == SZ_ONE);

  assign m0_rdata        = ltc2mc_avl_rdata_0;
  assign m1_rdata        = ltc2mc_avl_rdata_0;
  assign m0_rdata_valid  = rvalid & ~fifo_empty & ~head_id;
  assign m1_rdata_valid  = rvalid & ~fifo_empty &  head_id;
  assign err_unexp_rdata = err_q;
  assign dbg_state_o     = state_q;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    beats_left_d = beats_left_q;
    push         = 1'b0;
    if (!in_burst) begin
      if (accept) begin
        last_grant_d = win_id;
        if (sel_read_req) begin
          push = 1'b1;
        end else if (eff_size(sel_size) > SZ_ONE) begin
          state_d      = ST_WBURST;
          owner_d      = win_id;
          beats_left_d = eff_size(sel_size) - SZ_ONE;
        end
      end
    end else if (accept && sel_write_req) begin
      beats_left_d = beats_left_q - SZ_ONE;
      if (beats_left_q == SZ_ONE) state_d = ST_IDLE;
    end
  end

  always_comb begin
    ret_cnt_d = ret_cnt_q;
    if (rvalid && !fifo_empty) ret_cnt_d = pop ? '0 : (ret_rem - SZ_ONE);
  end

  always_ff @(posedge clkrst_avl_clk or posedge clkrst_avl_rst) begin
    if (clkrst_avl_rst) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      beats_left_q <= '0;
      ret_cnt_q    <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      beats_left_q <= beats_left_d;
      ret_cnt_q    <= ret_cnt_d;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      if (rvalid && fifo_empty) err_q <= 1'b1;
    end
  end

  always_ff @(posedge clkrst_avl_clk) begin
    if (push) begin
      tag_id_q[wr_ptr_q[PW-1:0]]   <= sel_id;
      tag_size_q[wr_ptr_q[PW-1:0]] <= eff_size(sel_size);
    end
  end

endmodule

// File: tb/tb_mcpu_avl_arb.sv
// Bench for mcpu_avl_arb: directed cycle vectors for the corner cases, then random traffic
// checked against a queue-based model of the arbitration and read-return rules.
module tb_mcpu_avl_arb;

  localparam int AW = 25, DW = 128, BEW = 16, SW = 5, DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [AW-1:0] m0_addr = '0, m1_addr = '0;
  logic [BEW-1:0] m0_be = '0, m1_be = '0;
  logic [DW-1:0] m0_wdata = '0, m1_wdata = '0;
  logic [SW-1:0] m0_size = '0, m1_size = '0;
  logic m0_burstbegin = 1'b0, m0_read_req = 1'b0, m0_write_req = 1'b0;
  logic m1_burstbegin = 1'b0, m1_read_req = 1'b0, m1_write_req = 1'b0;
  logic m0_ready, m1_ready, m0_rdata_valid, m1_rdata_valid;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic [AW-1:0] ltc_addr;
  logic [BEW-1:0] ltc_be;
  logic [DW-1:0] ltc_wdata;
  logic [SW-1:0] ltc_size;
  logic ltc_bb, ltc_rdq, ltc_wrq;
  logic ltc_ready = 1'b0;
  logic [DW-1:0] ltc_rdata = '0;
  logic ltc_rvalid = 1'b0;
  logic err_unexp, dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mcpu_avl_arb #(.AW(AW), .DW(DW), .BEW(BEW), .SW(SW), .RD_DEPTH(DEPTH)) dut (
    .clkrst_avl_clk(clk), .clkrst_avl_rst(rst),
    .m0_addr(m0_addr), .m0_be(m0_be), .m0_wdata(m0_wdata), .m0_size(m0_size),
    .m0_burstbegin(m0_burstbegin), .m0_read_req(m0_read_req), .m0_write_req(m0_write_req),
    .m0_ready(m0_ready), .m0_rdata(m0_rdata), .m0_rdata_valid(m0_rdata_valid),
    .m1_addr(m1_addr), .m1_be(m1_be), .m1_wdata(m1_wdata), .m1_size(m1_size),
    .m1_burstbegin(m1_burstbegin), .m1_read_req(m1_read_req), .m1_write_req(m1_write_req),
    .m1_ready(m1_ready), .m1_rdata(m1_rdata), .m1_rdata_valid(m1_rdata_valid),
    .ltc2mc_avl_addr_0(ltc_addr), .ltc2mc_avl_be_0(ltc_be), .ltc2mc_avl_wdata_0(ltc_wdata),
    .ltc2mc_avl_size_0(ltc_size), .ltc2mc_avl_burstbegin_0(ltc_bb),
    .ltc2mc_avl_read_req_0(ltc_rdq), .ltc2mc_avl_write_req_0(ltc_wrq),
    .ltc2mc_avl_ready_0(ltc_ready), .ltc2mc_avl_rdata_0(ltc_rdata),
    .ltc2mc_avl_rdata_valid_0(ltc_rvalid), .err_unexp_rdata(err_unexp),
    .dbg_state_o(dbg_state)
  );

  // One record per clock cycle: inputs, then the outputs expected mid-cycle.
  typedef struct {
    int rst, rd0, wr0, bb0, sz0, rd1, wr1, bb1, sz1, rdy, rv, rdat;
    int e_r0, e_r1, e_v0, e_v1, e_rdq, e_wrq, e_bb, e_err, e_st;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input vec_t v);
    vecs.push_back(v);
  endtask

  // Called at posedge+1: drive, check at the falling edge, return at the next posedge+1.
  task automatic apply(input vec_t v, input int idx);
    string p;
    p = $sformatf("row%0d", idx);
    rst = v.rst[0];
    m0_read_req = v.rd0[0]; m0_write_req = v.wr0[0]; m0_burstbegin = v.bb0[0];
    m0_size = v.sz0[SW-1:0];
    m1_read_req = v.rd1[0]; m1_write_req = v.wr1[0]; m1_burstbegin = v.bb1[0];
    m1_size = v.sz1[SW-1:0];
    ltc_ready = v.rdy[0]; ltc_rvalid = v.rv[0]; ltc_rdata = 128'(v.rdat);
    #4;
    chk({p, " m0_ready"}, 128'(m0_ready), 128'(v.e_r0));
    chk({p, " m1_ready"}, 128'(m1_ready), 128'(v.e_r1));
    chk({p, " m0_rdata_valid"}, 128'(m0_rdata_valid), 128'(v.e_v0));
    chk({p, " m1_rdata_valid"}, 128'(m1_rdata_valid), 128'(v.e_v1));
    chk({p, " read_req_0"}, 128'(ltc_rdq), 128'(v.e_rdq));
    chk({p, " write_req_0"}, 128'(ltc_wrq), 128'(v.e_wrq));
    chk({p, " burstbegin_0"}, 128'(ltc_bb), 128'(v.e_bb));
    chk({p, " err_unexp_rdata"}, 128'(err_unexp), 128'(v.e_err));
    chk({p, " state"}, 128'(dbg_state), 128'(v.e_st));
    chk({p, " m0_rdata"}, m0_rdata, 128'(v.rdat));
    chk({p, " m1_rdata"}, m1_rdata, 128'(v.rdat));
    @(posedge clk); #1;
  endtask

  // Random-phase reference model state.
  int  q_id[$];
  int  q_rem[$];
  bit  m_last, m_burst;
  int  m_owner, m_left;
  bit  rd[2], wr[2], bb[2], c[2], e_rdy[2], e_rv[2];
  int  sz[2], op, who, eff;
  logic [AW-1:0] ad[2];
  bit  rdy, rv, is_rd, e_rdq, e_wrq, e_bb, full;

  initial begin
    repeat (2) @(posedge clk);
    #1;

    //       rst rd0 wr0 bb0 sz0 rd1 wr1 bb1 sz1 rdy rv rdat   r0 r1 v0 v1 rdq wrq bb err st
    add('{1, 1,0,1,1, 1,0,1,1, 1,1,0,      0,0,0,0,0,0,0,0,0});
    // m0 read of 4, then four return beats
    add('{0, 1,0,1,4, 0,0,0,0, 1,0,0,      1,0,0,0,1,0,1,0,0});
    add('{0, 0,0,0,0, 0,0,0,0, 1,1,'hA0,   0,0,1,0,0,0,0,0,0});
    add('{0, 0,0,0,0, 0,0,0,0, 1,1,'hA1,   0,0,1,0,0,0,0,0,0});
    add('{0, 0,0,0,0, 0,0,0,0, 1,1,'hA2,   0,0,1,0,0,0,0,0,0});
    add('{0, 0,0,0,0, 0,0,0,0, 1,1,'hA3,   0,0,1,0,0,0,0,0,0});
    add('{0, 0,0,0,0, 0,0,0,0, 1,0,0,      0,0,0,0,0,0,0,0,0});
    // alternating single reads after reset, returns routed in issue order
    add('{1, 1,0,1,1, 1,0,1,1, 1,0,0,      0,0,0,0,0,0,0,0,0});
    add('{0, 1,0,1,1, 1,0,1,1, 1,0,0,      1,0,0,0,1,0,1,0,0});
    add('{0, 1,0,1,1, 1,0,1,1, 1,0,0,      0,1,0,0,1,0,1,0,0});
    add('{0, 1,0,1,1, 1,0,1,1, 1,0,0,      1,0,0,0,1,0,1,0,0});
    add('{0, 1,0,1,1, 1,0,1,1, 1,0,0,      0,1,0,0,1,0,1,0,0});
    add('{0, 0,0,0,0, 0,0,0,0, 1,1,1,      0,0,1,0,0,0,0,0,0});
    add('{0, 0,0,0,0, 0,0,0,0, 1,1,2,      0,0,0,1,0,0,0,0,0});
    add('{0, 0,0,0,0, 0,0,0,0, 1,1,3,      0,0,1,0,0,0,0,0,0});
    add('{0, 0,0,0,0, 0,0,0,0, 1,1,4,      0,0,0,1,0,0,0,0,0});
    // m1 write burst of 3 with ready 1,0,1,1; m0 read waits
    add('{0, 0,0,0,0, 0,1,1,3, 1,0,0,      0,1,0,0,0,1,1,0,0});
    add('{0, 1,0,1,1, 0,1,0,3, 0,0,0,      0,0,0,0,0,1,0,0,1});
    add('{0, 1,0,1,1, 0,1,0,3, 1,0,0,      0,1,0,0,0,1,0,0,1});
    add('{0, 1,0,1,1, 0,1,0,3, 1,0,0,      0,1,0,0,0,1,0,0,1});
    add('{0, 1,0,1,1, 0,0,0,0, 1,0,0,      1,0,0,0,1,0,1,0,0});
    add('{0, 0,0,0,0, 0,0,0,0, 1,1,'h55,   0,0,1,0,0,0,0,0,0});

    foreach (vecs[i]) apply(vecs[i], i);
    vecs.delete();

    // Tag FIFO full: four size-2 reads, fifth blocked until a whole burst returns
    add('{1, 0,0,0,0, 0,0,0,0, 0,0,0,      0,0,0,0,0,0,0,0,0});
    for (int i = 0; i < DEPTH; i++)
      add('{0, 1,0,1,2, 0,0,0,0, 1,0,0,    1,0,0,0,1,0,1,0,0});
    add('{0, 1,0,1,2, 0,0,0,0, 1,0,0,      0,0,0,0,0,0,0,0,0});
    add('{0, 1,0,1,2, 0,0,0,0, 1,1,'h10,   0,0,1,0,0,0,0,0,0});
    add('{0, 1,0,1,2, 0,0,0,0, 1,1,'h11,   0,0,1,0,0,0,0,0,0});
    add('{0, 1,0,1,2, 0,0,0,0, 1,0,0,      1,0,0,0,1,0,1,0,0});
    // Unexpected read data is dropped and the flag sticks until reset
    add('{1, 0,0,0,0, 0,0,0,0, 0,0,0,      0,0,0,0,0,0,0,0,0});
    add('{0, 0,0,0,0, 0,0,0,0, 0,1,'h77,   0,0,0,0,0,0,0,0,0});
    add('{0, 0,0,0,0, 0,0,0,0, 0,0,0,      0,0,0,0,0,0,0,1,0});
    add('{0, 0,0,0,0, 0,0,0,0, 1,0,0,      0,0,0,0,0,0,0,1,0});
    add('{1, 0,0,0,0, 0,0,0,0, 0,0,0,      0,0,0,0,0,0,0,0,0});
    // Reset with beats_left=5, then a fresh m1 single-beat write
    add('{0, 0,1,1,6, 0,0,0,0, 1,0,0,      1,0,0,0,0,1,1,0,0});
    add('{0, 0,1,0,6, 0,0,0,0, 0,0,0,      0,0,0,0,0,1,0,0,1});
    add('{1, 0,1,0,6, 1,0,1,1, 1,0,0,      0,0,0,0,0,0,0,0,0});
    add('{0, 0,1,0,6, 0,1,1,1, 1,0,0,      0,1,0,0,0,1,1,0,0});
    add('{0, 0,1,0,6, 0,0,0,0, 1,0,0,      0,0,0,0,0,0,0,0,0});
    add('{0, 0,0,0,0, 0,0,0,0, 0,1,'h99,   0,0,0,0,0,0,0,0,0});
    add('{0, 0,0,0,0, 0,0,0,0, 0,0,0,      0,0,0,0,0,0,0,1,0});

    foreach (vecs[i]) apply(vecs[i], 100 + i);

    // Random traffic against the model
    add('{1, 0,0,0,0, 0,0,0,0, 0,0,0,      0,0,0,0,0,0,0,0,0});
    apply(vecs[vecs.size()-1], 999);
    rst = 1'b0;
    m_last = 1'b1; m_burst = 1'b0; m_owner = 0; m_left = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      for (int p = 0; p < 2; p++) begin
        op = $urandom_range(0, 3);
        rd[p] = (op == 1);
        wr[p] = (op >= 2);
        bb[p] = ($urandom_range(0, 3) != 0);
        sz[p] = $urandom_range(0, 4);
        ad[p] = AW'($urandom);
      end
      rdy = ($urandom_range(0, 3) != 0);
      rv  = (q_id.size() > 0) && ($urandom_range(0, 1) == 1);
      m0_read_req = rd[0]; m0_write_req = wr[0]; m0_burstbegin = bb[0];
      m0_size = SW'(sz[0]); m0_addr = ad[0]; m0_wdata = {4{$urandom}};
      m1_read_req = rd[1]; m1_write_req = wr[1]; m1_burstbegin = bb[1];
      m1_size = SW'(sz[1]); m1_addr = ad[1]; m1_wdata = {4{$urandom}};
      ltc_ready = rdy; ltc_rvalid = rv; ltc_rdata = {4{$urandom}};
      #4;
      full = (q_id.size() >= DEPTH);
      e_rdy = '{0, 0}; e_rv = '{0, 0};
      e_rdq = 0; e_wrq = 0; e_bb = 0; is_rd = 0; who = -1;
      if (m_burst) begin
        who = m_owner;
        e_wrq = wr[who];
        e_rdy[who] = rdy;
      end else begin
        for (int p = 0; p < 2; p++) c[p] = rd[p] ? !full : (wr[p] && bb[p]);
        if (c[0] && c[1]) who = m_last ? 0 : 1;
        else if (c[0]) who = 0;
        else if (c[1]) who = 1;
        if (who >= 0) begin
          is_rd = rd[who];
          e_rdq = is_rd;
          e_wrq = !is_rd;
          e_bb  = bb[who];
          e_rdy[who] = rdy;
        end
      end
      if (rv) e_rv[q_id[0]] = 1;
      chk("rnd m0_ready", 128'(m0_ready), 128'(e_rdy[0]));
      chk("rnd m1_ready", 128'(m1_ready), 128'(e_rdy[1]));
      chk("rnd m0_rdata_valid", 128'(m0_rdata_valid), 128'(e_rv[0]));
      chk("rnd m1_rdata_valid", 128'(m1_rdata_valid), 128'(e_rv[1]));
      chk("rnd read_req_0", 128'(ltc_rdq), 128'(e_rdq));
      chk("rnd write_req_0", 128'(ltc_wrq), 128'(e_wrq));
      chk("rnd burstbegin_0", 128'(ltc_bb), 128'(e_bb));
      chk("rnd err_unexp_rdata", 128'(err_unexp), 128'(0));
      chk("rnd m1_rdata", m1_rdata, ltc_rdata);
      if (who >= 0) chk("rnd addr_0", 128'(ltc_addr), 128'(ad[who]));
      // advance the model by one clock
      if (rv) begin
        q_rem[0] = q_rem[0] - 1;
        if (q_rem[0] == 0) begin
          void'(q_id.pop_front());
          void'(q_rem.pop_front());
        end
      end
      if (m_burst) begin
        if (wr[who] && rdy) begin
          m_left--;
          if (m_left == 0) m_burst = 0;
        end
      end else if (who >= 0 && rdy) begin
        m_last = (who == 1);
        eff = (sz[who] == 0) ? 1 : sz[who];
        if (is_rd) begin
          q_id.push_back(who);
          q_rem.push_back(eff);
        end else if (eff > 1) begin
          m_burst = 1;
          m_owner = who;
          m_left  = eff - 1;
        end
      end
      @(posedge clk); #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
